// File: rtl/psum_spad_if.sv
// Handshake and data bundle between the psum scratchpad and its MAC / drain consumer.
interface psum_spad_if #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40
);
    logic                      start;
    logic [3:0]                cfg_len;
    logic [7:0]                cfg_pass;
    logic                      wb_en;
    logic signed [SIZEOUT-1:0] accum_in;
    logic signed [SIZEIN-1:0]  psum_out;
    logic                      clear_out;
    logic                      busy;
    logic                      dout_valid;
    logic                      dout_ready;
    logic signed [SIZEIN-1:0]  dout;
    logic                      done;

    modport master (
        output start, cfg_len, cfg_pass, wb_en, accum_in, dout_ready,
        input  psum_out, clear_out, busy, dout_valid, dout, done
    );

    modport slave (
        input  start, cfg_len, cfg_pass, wb_en, accum_in, dout_ready,
        output psum_out, clear_out, busy, dout_valid, dout, done
    );
endinterface

// File: rtl/psum_spad.sv
// Partial-sum scratchpad: accumulates MAC results over several passes, then drains them.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | feeding psum to MAC, writing back saturated results
//   DRAIN | streaming stored psums out with valid/ready
module psum_spad #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40,
    parameter int DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    psum_spad_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                   state;
    logic [3:0]               ptr;
    logic [3:0]               rd_ptr;
    logic [3:0]               len;
    logic [7:0]               npass;
    logic [7:0]               pass_cnt;
    logic                     busy_r;
    logic                     done_r;
    logic                     dout_valid_r;
    logic signed [SIZEIN-1:0] mem [DEPTH];
    logic signed [SIZEIN-1:0] sat_val;

    // Out of range exactly when the bits above the result's sign bit disagree with accum's sign.
    always_comb begin
        sat_val = bus.accum_in[SIZEIN-1:0];
        if (bus.accum_in[SIZEOUT-1:SIZEIN-1] != {(SIZEOUT-SIZEIN+1){bus.accum_in[SIZEOUT-1]}}) begin
            sat_val = bus.accum_in[SIZEOUT-1] ? {1'b1, {(SIZEIN-1){1'b0}}}
                                              : {1'b0, {(SIZEIN-1){1'b1}}};
        end
    end

    // Contents are intentionally not reset; pass 0 runs with clear_out so stale data is ignored.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCUM && bus.wb_en) begin
            mem[ptr] <= sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            npass        <= '0;
            pass_cnt     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !done_r) begin
                        state    <= ACCUM;
                        len      <= bus.cfg_len;
                        npass    <= bus.cfg_pass;
                        ptr      <= '0;
                        pass_cnt <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.wb_en) begin
                        if (ptr == len) begin
                            ptr <= '0;
                            if (pass_cnt == npass) begin
                                state        <= DRAIN;
                                rd_ptr       <= '0;
                                dout_valid_r <= 1'b1;
                            end else begin
                                pass_cnt <= pass_cnt + 8'd1;
                            end
                        end else begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (dout_valid_r && bus.dout_ready) begin
                        if (rd_ptr == len) begin
                            state        <= IDLE;
                            dout_valid_r <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.psum_out   = (state == ACCUM) ? mem[ptr] : '0;
    assign bus.clear_out  = (state == ACCUM) && (pass_cnt == 8'd0);
    assign bus.dout       = (state == DRAIN) ? mem[rd_ptr] : '0;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_psum_spad.sv
// Scoreboard bench for psum_spad: drained values are predicted at write time and popped on handshake.
module tb_psum_spad;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_spad_if #(.SIZEIN(16), .SIZEOUT(40)) bus ();

    psum_spad #(.SIZEIN(16), .SIZEOUT(40), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic signed [15:0] exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [15:0] sat16(input longint v);
        if (v > 32767)  return 16'sh7fff;
        if (v < -32768) return 16'sh8000;
        return v[15:0];
    endfunction

    task automatic wb(input longint v);
        bus.wb_en    = 1'b1;
        bus.accum_in = v[39:0];
        tick();
        bus.wb_en    = 1'b0;
        bus.accum_in = '0;
    endtask

    task automatic start_job(input logic [3:0] l, input logic [7:0] p);
        bus.cfg_len  = l;
        bus.cfg_pass = p;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic drain_check(input string name, input bit stall, output int hs);
        int budget;
        int cyc;
        bit prev_stall;
        logic signed [15:0] prev_dout;
        logic signed [15:0] e;
        hs = 0; cyc = 0; prev_stall = 0; prev_dout = '0; budget = 100;
        checks++;
        if (bus.dout_valid !== 1'b1) begin
            failures++; $display("FAIL %s_enter: dout_valid=%b expected 1", name, bus.dout_valid);
        end
        while (bus.dout_valid === 1'b1 && budget > 0) begin
            if (prev_stall) begin
                checks++;
                if (bus.dout !== prev_dout) begin
                    failures++; $display("FAIL %s_hold: dout=%0d expected %0d", name, bus.dout, prev_dout);
                end
            end
            bus.dout_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (bus.dout_ready) begin
                hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL %s_extra: dout=%0d with no expected entry", name, bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dout !== e) begin
                        failures++; $display("FAIL %s_data: dout=%0d expected %0d", name, bus.dout, e);
                    end
                end
            end
            prev_stall = !bus.dout_ready;
            prev_dout  = bus.dout;
            cyc++; budget--;
            tick();
        end
        bus.dout_ready = 1'b0;
        checks++;
        if (budget == 0) begin
            failures++; $display("FAIL %s_timeout: drain still valid after %0d cycles", name, cyc);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL %s_done: done=%b expected 1", name, bus.done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL %s_left: %0d entries not drained expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_done_low(input string name);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL %s_post: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b1; bus.wb_en = 1'b1; bus.accum_in = 40'sd123;
        bus.cfg_len = 4'd3; bus.cfg_pass = 8'd0; bus.dout_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout_valid !== 1'b0 ||
            bus.dout !== 16'sd0 || bus.psum_out !== 16'sd0 || bus.clear_out !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b dv=%b dout=%0d psum=%0d clr=%b expected all 0",
                     bus.busy, bus.done, bus.dout_valid, bus.dout, bus.psum_out, bus.clear_out);
        end
        rst = 1'b0; bus.start = 1'b0; bus.wb_en = 1'b0; bus.accum_in = '0; bus.dout_ready = 1'b0;
        tick();
    endtask

    task automatic test_single_pass;
        int hs;
        start_job(4'd3, 8'd0);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: busy=%b expected 1", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.clear_out !== 1'b1) begin
                failures++; $display("FAIL single_clear: entry %0d clear_out=%b expected 1", i, bus.clear_out);
            end
            exp_q.push_back(sat16(10 * (i + 1)));
            wb(10 * (i + 1));
        end
        drain_check("single", 1'b0, hs);
        tick();
        check_done_low("single");
    endtask

    task automatic test_multi_pass;
        int hs;
        longint model[2];
        longint nv;
        start_job(4'd1, 8'd2);
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 2; e++) begin
                checks++;
                if (bus.clear_out !== (p == 0)) begin
                    failures++; $display("FAIL multi_clear: pass %0d clear_out=%b expected %b", p, bus.clear_out, (p == 0));
                end
                if (p > 0) begin
                    checks++;
                    if (bus.psum_out !== model[e][15:0]) begin
                        failures++; $display("FAIL multi_psum: pass %0d entry %0d psum_out=%0d expected %0d", p, e, bus.psum_out, model[e]);
                    end
                end
                nv = ((p == 0) ? 0 : model[e]) + 5;
                model[e] = nv;
                wb(nv);
            end
        end
        exp_q.push_back(sat16(model[0]));
        exp_q.push_back(sat16(model[1]));
        drain_check("multi", 1'b0, hs);
        tick();
        check_done_low("multi");
    endtask

    task automatic test_saturation;
        int hs;
        longint vals[3];
        vals[0] = 100000; vals[1] = -70000; vals[2] = -5;
        start_job(4'd2, 8'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(sat16(vals[i]));
            wb(vals[i]);
        end
        drain_check("sat", 1'b0, hs);
        tick();
    endtask

    task automatic test_stall;
        int hs;
        longint vals[4];
        vals[0] = 7; vals[1] = -8; vals[2] = 9; vals[3] = -10;
        start_job(4'd3, 8'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(sat16(vals[i]));
            wb(vals[i]);
        end
        drain_check("stall", 1'b1, hs);
        checks++;
        if (hs != 4) begin failures++; $display("FAIL stall_hs: handshakes=%0d expected 4", hs); end
        tick();
        check_done_low("stall");
    endtask

    task automatic test_ignore_start;
        int hs;
        start_job(4'd1, 8'd0);
        wb(11);
        bus.cfg_len = 4'd3; bus.cfg_pass = 8'd5; bus.start = 1'b1;
        wb(22);
        bus.start = 1'b0;
        exp_q.push_back(16'sd11);
        exp_q.push_back(16'sd22);
        checks++;
        if (bus.dout_valid !== 1'b1) begin
            failures++; $display("FAIL ign_accum: dout_valid=%b expected 1 after 2 writes", bus.dout_valid);
        end
        bus.start = 1'b1; bus.dout_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b1 || bus.dout !== 16'sd11) begin
            failures++; $display("FAIL ign_drain: busy=%b dv=%b dout=%0d expected 1 1 11", bus.busy, bus.dout_valid, bus.dout);
        end
        drain_check("ign", 1'b0, hs);
        tick();
        check_done_low("ign");
        bus.wb_en = 1'b1; bus.accum_in = 40'sd99;
        tick(); tick();
        bus.wb_en = 1'b0; bus.accum_in = '0;
        checks++;
        if (bus.busy !== 1'b0 || bus.psum_out !== 16'sd0 || bus.clear_out !== 1'b0 || bus.dout !== 16'sd0) begin
            failures++; $display("FAIL idle_wb: busy=%b psum=%0d clr=%b dout=%0d expected 0 0 0 0", bus.busy, bus.psum_out, bus.clear_out, bus.dout);
        end
        start_job(4'd0, 8'd0);
        checks++;
        if (bus.psum_out !== 16'sd11 || bus.clear_out !== 1'b1) begin
            failures++; $display("FAIL idle_mem: psum=%0d clr=%b expected 11 1", bus.psum_out, bus.clear_out);
        end
        exp_q.push_back(16'sd5);
        wb(5);
        drain_check("len0", 1'b0, hs);
        tick();
    endtask

    task automatic test_rst_mid;
        int hs;
        longint want[3];
        start_job(4'd3, 8'd2);
        for (int i = 0; i < 4; i++) wb(100 * (i + 1));
        want[0] = 100; want[1] = 200;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.clear_out !== 1'b0 || bus.psum_out !== want[i][15:0]) begin
                failures++; $display("FAIL rmid_pass1: clr=%b psum=%0d expected 0 %0d", bus.clear_out, bus.psum_out, want[i]);
            end
            wb(want[i] + 1);
        end
        checks++;
        if (bus.psum_out !== 16'sd300) begin
            failures++; $display("FAIL rmid_ptr2: psum=%0d expected 300", bus.psum_out);
        end
        rst = 1'b1; bus.wb_en = 1'b1; bus.accum_in = 40'sd999;
        tick();
        rst = 1'b0; bus.wb_en = 1'b0; bus.accum_in = '0;
        checks++;
        if (bus.busy !== 1'b0 || bus.psum_out !== 16'sd0 || bus.clear_out !== 1'b0 ||
            bus.done !== 1'b0 || bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_abort: busy=%b psum=%0d clr=%b done=%b dv=%b expected all 0",
                                 bus.busy, bus.psum_out, bus.clear_out, bus.done, bus.dout_valid);
        end
        tick();
        check_done_low("rmid_idle");
        start_job(4'd3, 8'd0);
        want[0] = 101; want[1] = 201; want[2] = 300;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                checks++;
                if (bus.psum_out !== want[i][15:0]) begin
                    failures++; $display("FAIL rmid_mem: entry %0d psum=%0d expected %0d", i, bus.psum_out, want[i]);
                end
            end
            exp_q.push_back(sat16(i + 1));
            wb(i + 1);
        end
        drain_check("rmid_new", 1'b0, hs);
        tick();
    endtask

    task automatic test_back_to_back;
        int hs;
        start_job(4'd0, 8'd0);
        exp_q.push_back(16'sd77);
        wb(77);
        drain_check("b2b_first", 1'b0, hs);
        start_job(4'd0, 8'd0);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_ignored: busy=%b expected 0 (start on done)", bus.busy);
        end
        start_job(4'd0, 8'd0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL b2b_accept: busy=%b expected 1", bus.busy);
        end
        exp_q.push_back(-16'sd77);
        wb(-77);
        drain_check("b2b_second", 1'b0, hs);
        tick();
        check_done_low("b2b");
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_saturation();
        test_stall();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_spad.md
PSUM_SPAD -- requirements
Module: psum_spad

Interface
REQ-001 SHALL have parameter SIZEIN, 16, width of stored partial sums and of the MAC psum input.
REQ-002 SHALL have parameter SIZEOUT, 40, width of the MAC accumulator result written back.
REQ-003 SHALL have parameter DEPTH, 16, number of psum entries; power of two; DEPTH-1 must fit in cfg_len.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a job.
REQ-007 SHALL have port cfg_len  in  4  entries per pass minus 1, sampled on accepted start.
REQ-008 SHALL have port cfg_pass  in  8  number of passes minus 1, sampled on accepted start.
REQ-009 SHALL have port wb_en  in  1  accum_in is valid this cycle and must be written back.
REQ-010 SHALL have port accum_in  in  SIZEOUT  signed MAC accumulator result.
REQ-011 SHALL have port psum_out  out  SIZEIN  signed stored psum of the current entry, fed to the MAC internal psum input.
REQ-012 SHALL have port clear_out  out  1  MAC clear; tells the MAC to ignore stale psum on the first pass.
REQ-013 SHALL have port busy  out  1  high in ACCUM or DRAIN.
REQ-014 SHALL have port dout_valid  out  1  drain data valid.
REQ-015 SHALL have port dout_ready  in  1  drain consumer ready.
REQ-016 SHALL have port dout  out  SIZEIN  drained psum.
REQ-017 SHALL have port done  out  1  one-cycle pulse after the last drain handshake.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCUM and DRAIN; the encoding is free.
REQ-019 SHALL leave IDLE for ACCUM on start; it SHALL latch cfg_len/cfg_pass and zero ptr and pass_cnt; start SHALL be ignored outside IDLE.
REQ-020 SHALL, in ACCUM, drive psum_out = mem[ptr] combinationally from the current ptr (no read latency), and clear_out = (pass_cnt == 0).
REQ-021 SHALL, in ACCUM on a wb_en cycle, write mem[ptr] <= sat(accum_in) and then advance ptr; when ptr == len, ptr SHALL wrap to 0 and pass_cnt SHALL increment.
REQ-022 SHALL, for sat(), clamp signed accum_in to [-2^(SIZEIN-1), 2^(SIZEIN-1)-1] (16-bit: -32768..32767); in-range values SHALL pass unchanged.
REQ-023 SHALL, on wb_en with ptr == len and pass_cnt == pass, perform the write, go to DRAIN, and set rd_ptr = 0.
REQ-024 SHALL, in ACCUM cycles with wb_en low, hold all state; the block SHALL impose no minimum rate.
REQ-025 SHALL, in DRAIN, assert dout_valid with dout = mem[rd_ptr]; rd_ptr SHALL advance only on dout_valid & dout_ready; dout SHALL be stable while it is stalled.
REQ-026 SHALL, on the handshake of entry len, return to IDLE, drop dout_valid, and assert done for exactly the next cycle.
REQ-027 SHALL, outside ACCUM, drive psum_out = 0 and clear_out = 0; wb_en SHALL be ignored outside ACCUM.
REQ-028 SHALL, outside DRAIN, drive dout_valid = 0 and dout = 0.
REQ-029 SHALL, when cfg_len = 0, use one entry only; when cfg_pass = 0, run a single pass with clear_out high throughout.
REQ-030 SHALL, if start and done coincide, ignore start; start is accepted only in IDLE, the cycle after done.

Reset
REQ-031 SHALL, with rst high at a clock edge, enter IDLE and zero ptr, rd_ptr, pass_cnt, busy, done, dout_valid, dout, psum_out and clear_out; rst SHALL win over start and wb_en.
REQ-032 SHALL, when rst is asserted mid-ACCUM or mid-DRAIN, abort the job: no done pulse, no further writes.
REQ-033 SHALL NOT require mem contents to be reset; pass 0 clear_out makes stale data harmless.

Verification
REQ-034 SHALL cover: start cfg_len=3, cfg_pass=0; wb_en 4 cycles with accum_in = 10, 20, 30, 40 -> clear_out high all 4 cycles; DRAIN dout 10, 20, 30, 40; done pulses once.
REQ-035 SHALL cover: cfg_len=1, cfg_pass=2; each wb_en gives accum_in = psum_out + 5 -> psum_out in pass 1 = prior writes; final dout 15, 15; clear_out low in passes 1-2.
REQ-036 SHALL cover: accum_in = 40'sd100000, then -40'sd70000 -> stored/drained 32767, -32768; accum_in = -5 -> -5.
REQ-037 SHALL cover: DRAIN with dout_ready toggling 1,0,0,1 -> rd_ptr advances only on ready cycles; dout holds while stalled; exactly len+1 handshakes.
REQ-038 SHALL cover: start asserted during ACCUM and during DRAIN -> ignored, cfg unchanged; wb_en in IDLE -> no state change.
REQ-039 SHALL cover: rst pulse mid-ACCUM (ptr=2, pass_cnt=1) -> next cycle IDLE, busy=0, psum_out=0, no done; a new start then runs normally.
